// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared CDB types: PRF tag width and the result entry carried on the bus
`ifndef PRF_SIZE
`define PRF_SIZE 64
`endif

package cdb_pkg;
    localparam int CDB_TAG_W = $clog2(`PRF_SIZE);

    // Reused by the CDB listener / RS snoop logic
    typedef struct packed {
        logic [63:0]          value;
        logic [CDB_TAG_W-1:0] tag;
    } cdb_entry_t;
endpackage

// File: rtl/cdb_entry_fifo.sv
// rtl/cdb_entry_fifo.sv - DEPTH-entry circular buffer of CDB results with push/pop/clear
module cdb_entry_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  cdb_entry_t               wdata,
    output cdb_entry_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    cdb_entry_t       mem [DEPTH];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: consumers mask the head while empty
    always_ff @(posedge clock) begin
        if (push && !clear) mem[tail] <= wdata;
    end

    assign rdata = mem[head];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/cdb_result_sender.sv
// rtl/cdb_result_sender.sv - FU-side CDB sender: result buffer, retry on send_in_fail, starve flag
// Optional zero-latency path from fu_* to result_* when CDB_SENDER_BYPASS_EN is defined.
module cdb_result_sender
    import cdb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int TAG_W        = CDB_TAG_W
)
(
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fu_valid,
    input  logic [63:0]              fu_result,
    input  logic [TAG_W-1:0]         fu_dest_reg_idx,
    output logic                     fu_stall,
    output logic                     result_ready,
    output logic [63:0]              result_out,
    output logic [TAG_W-1:0]         dest_reg_idx,
    input  logic                     send_in_fail,
    input  logic                     squash,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     starve
);
    localparam int FAIL_W = $clog2(STARVE_LIMIT + 1);

    cdb_entry_t        push_entry;
    cdb_entry_t        head_entry;
    logic              buf_full;
    logic              buf_empty;
    logic              bypass_hit;
    logic              push;
    logic              pop;
    logic              fail_clear;
    logic [FAIL_W-1:0] fail_cnt;
    logic              starve_q;

    assign push_entry = '{value: fu_result, tag: fu_dest_reg_idx};

    cdb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .clear   (squash),
        .wdata   (push_entry),
        .rdata   (head_entry),
        .count   (count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    always_comb begin
        bypass_hit = 1'b0;
`ifdef CDB_SENDER_BYPASS_EN
        // Gated by reset_n so the fu_* path stays quiet while reset is held
        bypass_hit = reset_n && buf_empty && fu_valid && !squash;
`endif
        result_ready = !buf_empty || bypass_hit;
        result_out   = '0;
        dest_reg_idx = '0;
        if (bypass_hit) begin
            result_out   = fu_result;
            dest_reg_idx = fu_dest_reg_idx;
        end else if (!buf_empty) begin
            result_out   = head_entry.value;
            dest_reg_idx = head_entry.tag;
        end
    end

    // Full refuses an enqueue even when a dequeue frees a slot this cycle
    assign fu_stall   = buf_full;
    assign push       = fu_valid && !buf_full && !squash && !(bypass_hit && !send_in_fail);
    assign pop        = !buf_empty && !send_in_fail && !squash;
    assign fail_clear = squash || !result_ready || !send_in_fail;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fail_cnt <= '0;
            starve_q <= 1'b0;
        end else if (fail_clear) begin
            fail_cnt <= '0;
            starve_q <= 1'b0;
        end else begin
            if (fail_cnt < FAIL_W'(STARVE_LIMIT)) fail_cnt <= fail_cnt + FAIL_W'(1);
            starve_q <= (fail_cnt >= FAIL_W'(STARVE_LIMIT));
        end
    end

    assign starve = starve_q;
endmodule
